// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the centisecond stopwatch: FSM encodings,
// BCD digit widths and limits, and the packed six-digit time value.
package stopwatch_pkg;

  localparam int BCD_W = 4;

  localparam logic [BCD_W-1:0] DIGIT_MAX_9 = 4'd9;
  localparam logic [BCD_W-1:0] DIGIT_MAX_5 = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] m_tens;
    logic [BCD_W-1:0] m_ones;
    logic [BCD_W-1:0] s_tens;
    logic [BCD_W-1:0] s_ones;
    logic [BCD_W-1:0] cs_tens;
    logic [BCD_W-1:0] cs_ones;
  } bcd_time_t;

  // Two-digit BCD encoding of a binary value in 0..99.
  function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned value);
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] ones;
    tens = BCD_W'(value / 10);
    ones = BCD_W'(value % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/stopwatch_core_bcd_digit.sv
// One cascadable BCD digit counter: counts 0..MAX on inc, synchronous clear
// wins over increment, carry_out flags the increment that rolls it over.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter logic [BCD_W-1:0] MAX = DIGIT_MAX_9
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [BCD_W-1:0] value,
  output logic             carry_out
);

  assign carry_out = inc && (value == MAX);

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= (value == MAX) ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS.cc stopwatch: synchronizes the 100 Hz tick, runs the
// idle/run/pause/lap controller and drives six registered BCD display digits.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_LIMIT   = 59
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             tick_in,
  input  logic             start_stop,
  input  logic             lap,
  input  logic             clear,
  output logic [BCD_W-1:0] cs_tens,
  output logic [BCD_W-1:0] cs_ones,
  output logic [BCD_W-1:0] s_tens,
  output logic [BCD_W-1:0] s_ones,
  output logic [BCD_W-1:0] m_tens,
  output logic [BCD_W-1:0] m_ones,
  output logic             running,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam logic [2*BCD_W-1:0] MIN_LIMIT_BCD = to_bcd2(MIN_LIMIT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick_en;

  state_t    state_q;
  bcd_time_t live;
  bcd_time_t lap_q;
  bcd_time_t disp_q;

  logic       clear_cmd;
  logic       count_en;
  logic [5:0] carry;
  logic       min_at_limit;
  logic       wrap;

  // ---------------------------------------------------------------------------
  // tick_in is asynchronous data: synchronize, then detect the rising edge.
  // ---------------------------------------------------------------------------
  // NOTE: every flop below uses <= so all registers sample the pre-edge values;
  // a blocking = here would collapse the synchronizer chain into a single flop.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      edge_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign tick_en = sync_q[SYNC_STAGES-1] && !edge_q;

  // Counting and clearing are decided from the registered (pre-transition) state.
  assign clear_cmd = clear && (state_q == ST_PAUSE);
  assign count_en  = tick_en && ((state_q == ST_RUN) || (state_q == ST_LAP));

  // ---------------------------------------------------------------------------
  // Cascaded BCD time counter
  // ---------------------------------------------------------------------------
  bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs_ones (
    .clock_in  (clock_in),
    .reset     (reset),
    .clr       (clear_cmd),
    .inc       (count_en),
    .value     (live.cs_ones),
    .carry_out (carry[0])
  );

  bcd_digit #(.MAX(DIGIT_MAX_9)) u_cs_tens (
    .clock_in  (clock_in),
    .reset     (reset),
    .clr       (clear_cmd),
    .inc       (carry[0]),
    .value     (live.cs_tens),
    .carry_out (carry[1])
  );

  bcd_digit #(.MAX(DIGIT_MAX_9)) u_s_ones (
    .clock_in  (clock_in),
    .reset     (reset),
    .clr       (clear_cmd),
    .inc       (carry[1]),
    .value     (live.s_ones),
    .carry_out (carry[2])
  );

  bcd_digit #(.MAX(DIGIT_MAX_5)) u_s_tens (
    .clock_in  (clock_in),
    .reset     (reset),
    .clr       (clear_cmd),
    .inc       (carry[2]),
    .value     (live.s_tens),
    .carry_out (carry[3])
  );

  // Minutes wrap at MIN_LIMIT rather than at their natural digit limits, so the
  // wrap acts as a synchronous clear that overrides the minute increment.
  bcd_digit #(.MAX(DIGIT_MAX_9)) u_m_ones (
    .clock_in  (clock_in),
    .reset     (reset),
    .clr       (clear_cmd || wrap),
    .inc       (carry[3]),
    .value     (live.m_ones),
    .carry_out (carry[4])
  );

  bcd_digit #(.MAX(DIGIT_MAX_9)) u_m_tens (
    .clock_in  (clock_in),
    .reset     (reset),
    .clr       (clear_cmd || wrap),
    .inc       (carry[4]),
    .value     (live.m_tens),
    .carry_out (carry[5])
  );

  assign min_at_limit = ({live.m_tens, live.m_ones} == MIN_LIMIT_BCD);
  // carry[5] can only fire at 99:59.99, which is never below MIN_LIMIT.
  assign wrap = (carry[3] && min_at_limit) || carry[5];

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clear_cmd) begin
      overflow <= 1'b0;
    end else if (wrap) begin
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered running flag and lap latch.
  // Priority among pulses: clear > start_stop > lap, valid ones only.
  // ---------------------------------------------------------------------------
  // NOTE: the lap latch is a handful of flops, not a RAM, so it takes the async
  // reset like any other state; only true memory arrays are left unreset.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      running <= 1'b0;
      lap_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_stop) begin
            state_q <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            state_q <= ST_PAUSE;
            running <= 1'b0;
          end else if (lap) begin
            state_q <= ST_LAP;
            lap_q   <= live;
          end
        end
        ST_LAP: begin
          if (start_stop) begin
            state_q <= ST_PAUSE;
            running <= 1'b0;
          end else if (lap) begin
            state_q <= ST_RUN;
          end
        end
        ST_PAUSE: begin
          if (clear) begin
            state_q <= ST_IDLE;
            lap_q   <= '0;
          end else if (start_stop) begin
            state_q <= ST_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Registered display: lap latch while frozen, live count otherwise.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      disp_q <= '0;
    end else begin
      disp_q <= (state_q == ST_LAP) ? lap_q : live;
    end
  end

  assign m_tens  = disp_q.m_tens;
  assign m_ones  = disp_q.m_ones;
  assign s_tens  = disp_q.s_tens;
  assign s_ones  = disp_q.s_ones;
  assign cs_tens = disp_q.cs_tens;
  assign cs_ones = disp_q.cs_ones;

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Centisecond stopwatch counter that sits directly downstream of the 50 MHz→100 Hz clock divider. It samples the divider's 100 Hz square wave as data on the system clock and counts one centisecond per rising edge. It also holds an MM:SS.cc BCD time value, runs the start/pause/lap/clear state machine, and presents six BCD digits to the display multiplexer.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flops on tick_in (≥2).
- MIN_LIMIT, 59: highest minute value before wrap (≤99).

Ports:
- clock_in  input  1: 50 MHz system clock; the only clock.
- reset  input  1: asynchronous, active-high; clears all state.
- tick_in  input  1: 100 Hz output of the clock divider; treated as asynchronous data, never as a clock.
- start_stop  input  1: one-cycle pulse; toggles run/pause.
- lap  input  1: one-cycle pulse; freezes or unfreezes the display.
- clear  input  1: one-cycle pulse; zeroes the time while paused.
- cs_tens, cs_ones, s_tens, s_ones, m_tens, m_ones  output  4 each: displayed BCD digits.
- running  output  1: high in RUN or LAP.
- overflow  output  1: sticky; set on wrap past MIN_LIMIT:59.99.
- state  output  2: current FSM state encoding.

## Operation
- tick_in passes through SYNC_STAGES flops plus one edge-detect flop. A rising edge produces a one-cycle tick_en.
- Time counter: six BCD digits, cascaded. Limits per digit:
  - cs_ones and cs_tens count 0–9.
  - s_ones counts 0–9; s_tens counts 0–5.
  - Minutes count 00 to MIN_LIMIT, compared as a 2-digit BCD value.
- On tick_en with the pre-transition state in RUN or LAP, the counter increments by one centisecond with full carry propagation.
- At MIN_LIMIT:59.99, an increment gives 00:00.00 and sets overflow. Counting continues.
- States: IDLE=0, RUN=1, PAUSE=2, LAP=3.
  - IDLE: start_stop → RUN. lap and clear are ignored.
  - RUN: start_stop → PAUSE. lap → LAP, and the live time is copied to the display latch. clear is ignored.
  - LAP: the counter keeps running and the display shows the latch. lap → RUN. start_stop → PAUSE. clear is ignored.
  - PAUSE: start_stop → RUN. clear → IDLE; the counter, latch and overflow are zeroed on the same edge. lap is ignored.
- Simultaneous pulses resolve by priority: clear > start_stop > lap. Only the highest-priority pulse that is valid in the current state acts.
- Displayed digits equal the live counter in every state except LAP, where they equal the latch.
- Reset mid-count: all digits, the latch, overflow and running go to 0, and state goes to IDLE immediately (asynchronously).

## Timing
- Reset values: every digit output 0, running 0, overflow 0, state 0 (IDLE).
- Latency: a tick_in rising edge reaches the digit outputs SYNC_STAGES+2 clock_in edges later. With default parameters this is 4 clock_in edges.
- Control pulses: state, running and the latch update on the first clock_in edge after the pulse cycle.
- tick_en in the same cycle as start_stop: the increment decision uses the registered state before the transition.
  - Example: in RUN, start_stop plus tick_en still counts that centisecond, then the block pauses.
- tick_in must be high and low for at least SYNC_STAGES+1 cycles each to be detected. At 100 Hz with a 50 MHz clock this holds by a wide margin.
- Every output is registered. No combinational path runs from any input to any output.

## Structure
- Shared package stopwatch_pkg holds:
  - State encodings (ST_IDLE, ST_RUN, ST_PAUSE, ST_LAP).
  - BCD_W=4.
  - Digit limit constants (9, 5).
- Sub-module bcd_digit: one BCD digit counter with a parameter for the maximum value. Ports: clock_in, reset, clr, inc, value[3:0], carry_out. carry_out asserts when inc is high and value equals the maximum.
- The six digits are instances of bcd_digit. The minute wrap compare and the carry chain live in stopwatch_core.

## Test plan
- Reset, start_stop, 100 tick_in periods → digits read 00:01.00; running=1; state=1.
- Start from 00:59.99 (preloaded by 5999 ticks), then one tick → 01:00.00; then start_stop → state=2, and further ticks leave the digits unchanged.
- Start from 59:59.99 with MIN_LIMIT=59, then one tick → 00:00.00 and overflow=1. Then start_stop and clear → all zero, overflow=0, state=0.
- At 00:12.34 in RUN, pulse lap, then 50 ticks → the display holds 00:12.34. Pulse lap again → the display shows 00:12.84.
- tick_en coincident with start_stop in RUN at 00:00.05 → the display reads 00:00.06, state=2. clear and start_stop together in PAUSE → state=0, digits zero.
- Assert reset asynchronously mid-count at 00:03.21 → all outputs 0 before the next clock_in edge. After release, tick_in edges are ignored until start_stop is pulsed.
